jc_phase_tally: RTL and testbench

//   Downstream consumer of the 10-phase Johnson-counter decode (one-hot a0..a9).

---
 rtl/jc_pkg.sv | 29 ++
 rtl/bcd_digit.sv | 25 ++
 rtl/jc_phase_tally.sv | 138 +++++++++++++
 tb/tb_jc_phase_tally.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/jc_pkg.sv
// Shared constants and the phase-bus decoder for the Johnson-counter tally.
package jc_pkg;

  localparam int unsigned NPHASE  = 10;
  localparam int unsigned BCD_W   = 4;
  localparam logic [3:0]  BCD_MAX = 4'd9;

  typedef struct packed {
    logic             legal;
    logic [BCD_W-1:0] idx;
  } ph_dec_t;

  // Exactly one set bit is legal; idx is the position of the highest set bit.
  function automatic ph_dec_t onehot10_to_idx(input logic [NPHASE-1:0] ph);
    ph_dec_t     d;
    int unsigned n;
    d = '0;
    n = 0;
    for (int unsigned i = 0; i < NPHASE; i++) begin
      if (ph[i]) begin
        d.idx = BCD_W'(i);
        n     = n + 1;
      end
    end
    d.legal = (n == 1);
    return d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register: synchronous clear, increment with 9->0 wrap and carry out.
module bcd_digit
  import jc_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] q,
  output logic             carry_out_c
);

  logic [BCD_W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_q <= '0;
    end else if (inc) begin
      r_q <= (r_q == BCD_MAX) ? '0 : r_q + BCD_W'(1);
    end
  end

  assign q           = r_q;
  assign carry_out_c = inc && (r_q == BCD_MAX);

endmodule

// File: rtl/jc_phase_tally.sv
// Registers the one-hot phase bus, tracks the phase as BCD digit 0, counts
// full cycles into upper BCD digits, flags illegal input and offers a snapshot.
module jc_phase_tally
  import jc_pkg::*;
#(
  parameter int unsigned NDIG = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NPHASE-1:0]     ph,
  input  logic                  err_clr,
  input  logic                  snap_req,
  input  logic                  snap_ack,
  output logic [BCD_W*NDIG-1:0] cnt,
  output logic [BCD_W*NDIG-1:0] snap_cnt,
  output logic                  snap_valid,
  output logic                  err_onehot,
  output logic                  err_seq,
  output logic                  ovf
);

  localparam int unsigned CNT_W = BCD_W * NDIG;

  logic [NPHASE-1:0] r_ph_q;
  logic              r_ph_vld;
  logic              r_first;
  logic [BCD_W-1:0]  r_digit0;
  logic              r_err_onehot;
  logic              r_err_seq;
  logic              r_ovf;
  logic [CNT_W-1:0]  r_snap_cnt;
  logic              r_snap_valid;

  ph_dec_t           w_dec;
  logic [BCD_W-1:0]  w_succ;
  logic              w_upd;
  logic              w_wrap;
  logic              w_oh_err;
  logic              w_seq_err;
  logic [CNT_W-1:0]  w_cnt;
  logic [NDIG-1:1]   w_inc;
  logic [NDIG-1:1]   w_cy;

  assign w_dec  = onehot10_to_idx(r_ph_q);
  assign w_succ = (r_digit0 == BCD_MAX) ? '0 : r_digit0 + BCD_W'(1);

  // r_ph_vld keeps the reset value of ph_q from being judged as a sampled phase.
  always_comb begin
    w_upd     = 1'b0;
    w_wrap    = 1'b0;
    w_oh_err  = 1'b0;
    w_seq_err = 1'b0;
    if (r_ph_vld) begin
      if (!w_dec.legal) begin
        w_oh_err = 1'b1;
      end else if (r_first) begin
        w_upd = 1'b1;
      end else if (w_dec.idx == r_digit0) begin
        w_upd = 1'b0;
      end else if (w_dec.idx == w_succ) begin
        w_upd  = 1'b1;
        w_wrap = (r_digit0 == BCD_MAX);
      end else begin
        w_upd     = 1'b1;
        w_seq_err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ph_q   <= '0;
      r_ph_vld <= 1'b0;
      r_first  <= 1'b1;
      r_digit0 <= '0;
    end else begin
      r_ph_q   <= ph;
      r_ph_vld <= 1'b1;
      if (w_upd) begin
        r_digit0 <= w_dec.idx;
        r_first  <= 1'b0;
      end
    end
  end

  // Sticky flags: a flag raised this cycle survives a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_onehot <= 1'b0;
      r_err_seq    <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_err_onehot <= w_oh_err          | (r_err_onehot & ~err_clr);
      r_err_seq    <= w_seq_err         | (r_err_seq    & ~err_clr);
      r_ovf        <= w_cy[NDIG-1]      | (r_ovf        & ~err_clr);
    end
  end

  assign w_cnt[BCD_W-1:0] = r_digit0;
  assign w_inc[1]         = w_wrap;

  // Upper digits form a same-cycle ripple carry chain.
  for (genvar i = 1; i < NDIG; i++) begin : g_dig
    if (i > 1) begin : g_link
      assign w_inc[i] = w_cy[i-1];
    end
    bcd_digit u_dig (
      .clk         (clk),
      .clr         (rst),
      .inc         (w_inc[i]),
      .q           (w_cnt[i*BCD_W +: BCD_W]),
      .carry_out_c (w_cy[i])
    );
  end

  // Single-entry snapshot; a request arriving with the ack is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_snap_cnt   <= '0;
      r_snap_valid <= 1'b0;
    end else if (r_snap_valid) begin
      if (snap_ack) begin
        r_snap_valid <= 1'b0;
      end
    end else if (snap_req) begin
      r_snap_cnt   <= w_cnt;
      r_snap_valid <= 1'b1;
    end
  end

  assign cnt        = w_cnt;
  assign snap_cnt   = r_snap_cnt;
  assign snap_valid = r_snap_valid;
  assign err_onehot = r_err_onehot;
  assign err_seq    = r_err_seq;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_jc_phase_tally.sv
// Directed bench for jc_phase_tally: a 4-digit instance for most steps and a
// 2-digit instance for the upper-digit overflow.
module tb_jc_phase_tally;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  ph;
  logic        err_clr;
  logic        snap_req;
  logic        snap_ack;
  logic [15:0] cnt;
  logic [15:0] snap_cnt;
  logic        snap_valid;
  logic        err_onehot;
  logic        err_seq;
  logic        ovf;

  logic        rst2;
  logic [9:0]  ph2;
  logic        err_clr2;
  logic        snap_req2;
  logic        snap_ack2;
  logic [7:0]  cnt2;
  logic [7:0]  snap_cnt2;
  logic        snap_valid2;
  logic        err_onehot2;
  logic        err_seq2;
  logic        ovf2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  jc_phase_tally #(.NDIG(4)) dut (
    .clk(clk), .rst(rst), .ph(ph), .err_clr(err_clr),
    .snap_req(snap_req), .snap_ack(snap_ack), .cnt(cnt),
    .snap_cnt(snap_cnt), .snap_valid(snap_valid),
    .err_onehot(err_onehot), .err_seq(err_seq), .ovf(ovf)
  );

  jc_phase_tally #(.NDIG(2)) dut2 (
    .clk(clk), .rst(rst2), .ph(ph2), .err_clr(err_clr2),
    .snap_req(snap_req2), .snap_ack(snap_ack2), .cnt(cnt2),
    .snap_cnt(snap_cnt2), .snap_valid(snap_valid2),
    .err_onehot(err_onehot2), .err_seq(err_seq2), .ovf(ovf2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] onehot(input int p);
    logic [9:0] v;
    v = 10'd1;
    return v << p;
  endfunction

  int seq4 [9] = '{2, 3, 3, 6, 7, 8, 9, 0, 0};

  initial begin
    rst = 1'b1; ph = 10'h001; err_clr = 1'b0; snap_req = 1'b1; snap_ack = 1'b0;
    rst2 = 1'b1; ph2 = 10'h000; err_clr2 = 1'b0; snap_req2 = 1'b0; snap_ack2 = 1'b0;

    // T1 reset
    tick(); tick();
    rst = 1'b0; snap_req = 1'b0;
    tick();
    chk("t1_cnt", cnt, 16'h0000);
    chk("t1_snap_valid", {15'd0, snap_valid}, 16'h0000);
    chk("t1_flags", {13'd0, err_onehot, err_seq, ovf}, 16'h0000);

    // T2 sweep 0..9,0,1
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      ph = onehot(i % 10);
      tick();
      if (i == 1) chk("t2_lat_phase0", cnt, 16'h0000);
      if (i == 2) chk("t2_lat_phase1", cnt, 16'h0001);
    end
    tick();
    chk("t2_cnt_end", cnt, 16'h0011);
    chk("t2_flags", {13'd0, err_onehot, err_seq, ovf}, 16'h0000);

    // T3 illegal one-hot
    ph = 10'h003; tick();
    ph = 10'h000; tick();
    chk("t3_err_two_bits", {15'd0, err_onehot}, 16'h0001);
    chk("t3_cnt_held", cnt, 16'h0011);
    ph = 10'h002; tick();
    chk("t3_err_zero_bits", {15'd0, err_onehot}, 16'h0001);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("t3_err_cleared", {15'd0, err_onehot}, 16'h0000);
    chk("t3_cnt_after_clr", cnt, 16'h0011);
    ph = 10'h000; tick();
    ph = 10'h002; err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("t3_set_wins", {15'd0, err_onehot}, 16'h0001);

    // T4 sequence errors and carry
    rst = 1'b1; tick(); rst = 1'b0;
    for (int j = 0; j < 9; j++) begin
      ph = onehot(seq4[j]);
      tick();
      if (j == 3) begin
        chk("t4_hold_no_err", {15'd0, err_seq}, 16'h0000);
        chk("t4_hold_cnt", cnt, 16'h0003);
      end
      if (j == 4) begin
        chk("t4_seq_err", {15'd0, err_seq}, 16'h0001);
        chk("t4_resync", cnt, 16'h0006);
      end
    end
    chk("t4_carry", cnt, 16'h0010);
    chk("t4_no_onehot_err", {15'd0, err_onehot}, 16'h0000);

    // T6 snapshot handshake
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i <= 42; i++) begin
      ph = onehot(i % 10);
      tick();
    end
    tick();
    chk("t6_cnt_42", cnt, 16'h0042);
    snap_req = 1'b1; tick(); snap_req = 1'b0;
    chk("t6_snap_cnt", snap_cnt, 16'h0042);
    chk("t6_snap_valid", {15'd0, snap_valid}, 16'h0001);
    ph = onehot(3); tick(); tick();
    chk("t6_cnt_43", cnt, 16'h0043);
    snap_req = 1'b1; tick();
    chk("t6_frozen", snap_cnt, 16'h0042);
    snap_ack = 1'b1; tick(); snap_ack = 1'b0;
    chk("t6_ack_clears", {15'd0, snap_valid}, 16'h0000);
    chk("t6_req_with_ack_dropped", snap_cnt, 16'h0042);
    tick(); snap_req = 1'b0;
    chk("t6_recapture", snap_cnt, 16'h0043);
    chk("t6_recapture_valid", {15'd0, snap_valid}, 16'h0001);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_rst_valid", {15'd0, snap_valid}, 16'h0000);
    chk("t6_rst_snap_cnt", snap_cnt, 16'h0000);

    // T5 overflow on the 2-digit instance
    rst2 = 1'b0;
    for (int i = 0; i <= 1000; i++) begin
      ph2 = onehot(i % 10);
      tick();
      if (i == 91) begin
        chk("t5_nine_wraps", {8'd0, cnt2}, 16'h0090);
        chk("t5_no_ovf_yet", {15'd0, ovf2}, 16'h0000);
      end
      if (i == 101) begin
        chk("t5_first_ovf_cnt", {8'd0, cnt2}, 16'h0000);
        chk("t5_first_ovf", {15'd0, ovf2}, 16'h0001);
      end
    end
    tick();
    chk("t5_cnt_100_wraps", {8'd0, cnt2}, 16'h0000);
    chk("t5_ovf", {15'd0, ovf2}, 16'h0001);
    chk("t5_no_seq_err", {14'd0, err_seq2, err_onehot2}, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
